// File: rtl/auth_pkg.sv
// Credential tables, state encoding and sizing helpers
// shared by the login controller and its digit matcher.
package auth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PSWD   = 2'd1,
        ST_AUTH   = 2'd2,
        ST_LOCKED = 2'd3
    } auth_state_e;

    localparam int TBL_USERS = 4;
    localparam int TBL_ID    = 4;
    localparam int TBL_PSWD  = 6;
    localparam int TU_W      = $clog2(TBL_USERS);
    localparam int TI_W      = $clog2(TBL_ID);
    localparam int TP_W      = $clog2(TBL_PSWD);

    localparam logic [3:0] ID_TABLE [TBL_USERS][TBL_ID] = '{
        '{4'h8, 4'h5, 4'h2, 4'h2},
        '{4'h4, 4'h7, 4'h0, 4'h0},
        '{4'h5, 4'h9, 4'h2, 4'h8},
        '{4'h2, 4'h0, 4'h7, 4'h1}
    };

    localparam logic [3:0] PSWD_TABLE [TBL_USERS][TBL_PSWD] = '{
        '{4'hA, 4'h5, 4'h4, 4'hE, 4'h3, 4'h2},
        '{4'hE, 4'hE, 4'hE, 4'h4, 4'h2, 4'h0},
        '{4'hF, 4'h2, 4'h4, 4'h6, 4'h3, 4'h0},
        '{4'hA, 4'hA, 4'hB, 4'h4, 4'h3, 4'h1}
    };

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits to hold 0..n inclusive, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Positions outside the stored table read as digit 0.
    function automatic logic [3:0] id_digit(input int u, input int d);
        if (u >= 0 && u < TBL_USERS && d >= 0 && d < TBL_ID)
            return ID_TABLE[TU_W'(u)][TI_W'(d)];
        return 4'h0;
    endfunction

    function automatic logic [3:0] pswd_digit(input int u, input int d);
        if (u >= 0 && u < TBL_USERS && d >= 0 && d < TBL_PSWD)
            return PSWD_TABLE[TU_W'(u)][TP_W'(d)];
        return 4'h0;
    endfunction

endpackage

// File: rtl/auth_digit_matcher.sv
// Per-user ID match tracking with lowest-index
// selection of the surviving candidate.
module auth_digit_matcher
    import auth_pkg::*;
#(
    parameter int NUM_USERS = 4,
    parameter int DIGIT_W   = 4,
    parameter int POS_W     = 3,
    parameter int USER_W    = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_enter,
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic [POS_W-1:0]   i_pos,
    output logic               o_any,
    output logic [USER_W-1:0]  o_sel
);
    logic [NUM_USERS-1:0] r_match;
    logic [NUM_USERS-1:0] w_eq;
    logic [NUM_USERS-1:0] w_match_n;

    always_comb begin
        w_eq = '0;
        for (int u = 0; u < NUM_USERS; u++)
            w_eq[u] = (i_digit == DIGIT_W'(id_digit(u, int'(i_pos))));
    end

    assign w_match_n = r_match & w_eq;
    assign o_any     = |w_match_n;

    // Scan downward so the lowest matching index wins.
    always_comb begin
        o_sel = '0;
        for (int u = NUM_USERS - 1; u >= 0; u--)
            if (w_match_n[u]) o_sel = USER_W'(u);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_match <= '1;
        else if (i_clear) r_match <= '1;
        else if (i_enter) r_match <= w_match_n;
    end

endmodule

// File: rtl/param_user_authenticator.sv
// Multi-user hex-digit login controller with failure
// lockout and inter-digit entry timeout.
module param_user_authenticator
    import auth_pkg::*;
#(
    parameter int NUM_USERS      = 4,
    parameter int ID_DIGITS      = 4,
    parameter int PSWD_DIGITS    = 6,
    parameter int DIGIT_W        = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                                          Clk,
    input  logic                                          Reset,
    input  logic [DIGIT_W-1:0]                            InputSwitches,
    input  logic                                          EnterPswd,
    input  logic                                          LogOutPulse,
    output logic                                          Successful,
    output logic [$clog2(NUM_USERS+1)-1:0]                PlayerID,
    output logic                                          IDVerified,
    output logic                                          Locked,
    output logic [1:0]                                    AuthState,
    output logic [cnt_w(max_i(ID_DIGITS,PSWD_DIGITS))-1:0] DigitCount,
    output logic [cnt_w(MAX_FAILS)-1:0]                   FailCount
);
    localparam int USER_W = $clog2(NUM_USERS + 1);
    localparam int DC_W   = cnt_w(max_i(ID_DIGITS, PSWD_DIGITS));
    localparam int FC_W   = cnt_w(MAX_FAILS);
    localparam int TO_W   = cnt_w(TIMEOUT_CYCLES);
    localparam int LK_W   = cnt_w(LOCKOUT_CYCLES);

    auth_state_e       r_state, w_state_n;
    logic [DC_W-1:0]   r_dcnt, w_dcnt_n;
    logic [FC_W-1:0]   r_fail, w_fail_n;
    logic              r_mis, w_mis_n, w_mis_cur;
    logic [USER_W-1:0] r_sel, w_sel_n, w_sel;
    logic [LK_W-1:0]   r_lock, w_lock_n;
    logic [TO_W-1:0]   r_idle;
    logic              r_succ, r_idv, r_lck;
    logic [USER_W-1:0] r_pid;
    logic              w_enter, w_any, w_tmo, w_idle_act;
    logic              w_last_id, w_last_pw, w_fail_evt;

    assign w_enter    = EnterPswd && !LogOutPulse;
    assign w_idle_act = (r_state == ST_IDLE && r_dcnt != '0) || r_state == ST_PSWD;
    assign w_tmo      = w_idle_act && (r_idle == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_last_id  = (r_dcnt == DC_W'(ID_DIGITS - 1));
    assign w_last_pw  = (r_dcnt == DC_W'(PSWD_DIGITS - 1));

    auth_digit_matcher #(
        .NUM_USERS (NUM_USERS),
        .DIGIT_W   (DIGIT_W),
        .POS_W     (DC_W),
        .USER_W    (USER_W)
    ) u_matcher (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_clear (w_state_n != ST_IDLE || w_dcnt_n == '0),
        .i_enter (r_state == ST_IDLE && w_enter),
        .i_digit (InputSwitches),
        .i_pos   (r_dcnt),
        .o_any   (w_any),
        .o_sel   (w_sel)
    );

    always_comb begin
        w_state_n  = r_state;
        w_dcnt_n   = r_dcnt;
        w_fail_n   = r_fail;
        w_mis_n    = r_mis;
        w_sel_n    = r_sel;
        w_lock_n   = r_lock;
        w_fail_evt = 1'b0;
        w_mis_cur  = r_mis | (InputSwitches !=
                     DIGIT_W'(pswd_digit(int'(r_sel), int'(r_dcnt))));
        case (r_state)
            ST_IDLE: begin
                if (LogOutPulse) begin
                    w_dcnt_n = '0;
                end else if (w_enter) begin
                    if (!w_last_id) begin
                        w_dcnt_n = r_dcnt + 1'b1;
                    end else if (w_any) begin
                        w_state_n = ST_PSWD;
                        w_sel_n   = w_sel;
                        w_dcnt_n  = '0;
                        w_mis_n   = 1'b0;
                    end else begin
                        w_fail_evt = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_dcnt_n = '0;
                end
            end
            ST_PSWD: begin
                if (LogOutPulse || (!w_enter && w_tmo)) begin
                    w_state_n = ST_IDLE;
                    w_dcnt_n  = '0;
                    w_mis_n   = 1'b0;
                end else if (w_enter) begin
                    if (!w_last_pw) begin
                        w_dcnt_n = r_dcnt + 1'b1;
                        w_mis_n  = w_mis_cur;
                    end else if (!w_mis_cur) begin
                        w_state_n = ST_AUTH;
                        w_dcnt_n  = '0;
                        w_fail_n  = '0;
                        w_mis_n   = 1'b0;
                    end else begin
                        w_fail_evt = 1'b1;
                    end
                end
            end
            ST_AUTH: begin
                if (LogOutPulse) w_state_n = ST_IDLE;
            end
            ST_LOCKED: begin
                if (r_lock == '0) begin
                    w_state_n = ST_IDLE;
                    w_fail_n  = '0;
                end else begin
                    w_lock_n = r_lock - 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (w_fail_evt) begin
            w_dcnt_n = '0;
            w_mis_n  = 1'b0;
            w_fail_n = r_fail + 1'b1;
            if (r_fail == FC_W'(MAX_FAILS - 1)) begin
                w_state_n = ST_LOCKED;
                w_lock_n  = LK_W'(LOCKOUT_CYCLES - 1);
            end else begin
                w_state_n = ST_IDLE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_dcnt  <= '0;
            r_fail  <= '0;
            r_mis   <= 1'b0;
            r_sel   <= '0;
            r_lock  <= '0;
            r_idle  <= '0;
            r_succ  <= 1'b0;
            r_pid   <= '0;
            r_idv   <= 1'b0;
            r_lck   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_dcnt  <= w_dcnt_n;
            r_fail  <= w_fail_n;
            r_mis   <= w_mis_n;
            r_sel   <= w_sel_n;
            r_lock  <= w_lock_n;
            // Idle time restarts on any accepted digit or leaving entry.
            if (!w_idle_act || w_enter || LogOutPulse || w_tmo)
                r_idle <= '0;
            else
                r_idle <= r_idle + 1'b1;
            r_succ  <= (w_state_n == ST_AUTH);
            r_pid   <= (w_state_n == ST_AUTH) ? w_sel_n + 1'b1 : '0;
            r_idv   <= (w_state_n == ST_PSWD) || (w_state_n == ST_AUTH);
            r_lck   <= (w_state_n == ST_LOCKED);
        end
    end

    assign Successful = r_succ;
    assign PlayerID   = r_pid;
    assign IDVerified = r_idv;
    assign Locked     = r_lck;
    assign AuthState  = r_state;
    assign DigitCount = r_dcnt;
    assign FailCount  = r_fail;

endmodule

// File: tb/tb_param_user_authenticator.sv
// Scenario-driven bench for the login controller;
// expected snapshots are queued and compared per task.
module tb_param_user_authenticator;

    typedef struct packed {
        logic [1:0] st;
        logic       succ;
        logic [2:0] pid;
        logic       idv;
        logic       lck;
        logic [2:0] dc;
        logic [1:0] fc;
    } obs_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] InputSwitches = 4'h0;
    logic       EnterPswd = 1'b0;
    logic       LogOutPulse = 1'b0;
    logic       Successful;
    logic [2:0] PlayerID;
    logic       IDVerified;
    logic       Locked;
    logic [1:0] AuthState;
    logic [2:0] DigitCount;
    logic [1:0] FailCount;

    int    n_chk = 0;
    int    n_err = 0;
    obs_t  q_exp[$];
    obs_t  q_got[$];
    string q_nm[$];

    always #5 Clk = ~Clk;

    param_user_authenticator dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .InputSwitches (InputSwitches),
        .EnterPswd     (EnterPswd),
        .LogOutPulse   (LogOutPulse),
        .Successful    (Successful),
        .PlayerID      (PlayerID),
        .IDVerified    (IDVerified),
        .Locked        (Locked),
        .AuthState     (AuthState),
        .DigitCount    (DigitCount),
        .FailCount     (FailCount)
    );

    function automatic obs_t cur();
        obs_t o;
        o.st = AuthState; o.succ = Successful; o.pid = PlayerID;
        o.idv = IDVerified; o.lck = Locked;
        o.dc = DigitCount; o.fc = FailCount;
        return o;
    endfunction

    // Flags follow from the state the bench expects.
    function automatic obs_t mk(input logic [1:0] st, input logic [2:0] pid,
                                input logic [2:0] dc, input logic [1:0] fc);
        obs_t m;
        m.st = st; m.succ = (st == 2'd2); m.pid = pid;
        m.idv = (st == 2'd1) || (st == 2'd2); m.lck = (st == 2'd3);
        m.dc = dc; m.fc = fc;
        return m;
    endfunction

    task automatic mark(input string nm, input obs_t e);
        q_nm.push_back(nm);
        q_exp.push_back(e);
        q_got.push_back(cur());
    endtask

    task automatic keys(input logic [23:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            InputSwitches = v[4*(n-1-i) +: 4];
            EnterPswd = 1'b1;
            @(negedge Clk);
        end
        EnterPswd = 1'b0;
    endtask

    task automatic logout();
        LogOutPulse = 1'b1;
        @(negedge Clk);
        LogOutPulse = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, g; string nm;
        #3;
        mark("reset_hold", mk(0, 0, 0, 0));
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        mark("reset_release", mk(0, 0, 0, 0));
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_nm.pop_front();
            n_chk++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s got %h expected %h", nm, g, e);
            end
        end
    endtask

    task automatic test_bad_pswd();
        obs_t e, g; string nm;
        keys(24'h2071, 4);
        mark("id_2071", mk(1, 0, 0, 0));
        keys(24'hAAB430, 6);
        mark("bad_pw_fail", mk(0, 0, 0, 1));
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_nm.pop_front();
            n_chk++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s got %h expected %h", nm, g, e);
            end
        end
    endtask

    task automatic test_back_to_back_login();
        obs_t e, g; string nm;
        keys(24'h8522, 4);
        mark("id_8522", mk(1, 0, 0, 1));
        keys(24'hA54E3, 5);
        mark("pw_5_digits", mk(1, 0, 5, 1));
        keys(24'h2, 1);
        mark("auth_user1", mk(2, 1, 0, 0));
        keys(24'h1, 1);
        mark("auth_ignores_enter", mk(2, 1, 0, 0));
        logout();
        mark("logout_user1", mk(0, 0, 0, 0));
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_nm.pop_front();
            n_chk++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s got %h expected %h", nm, g, e);
            end
        end
    endtask

    task automatic test_lockout();
        obs_t e, g; string nm;
        keys(24'h1111, 4);
        mark("wrong_id_1", mk(0, 0, 0, 1));
        keys(24'h1111, 4);
        mark("wrong_id_2", mk(0, 0, 0, 2));
        keys(24'h1111, 4);
        mark("lock_enter", mk(3, 0, 0, 3));
        repeat (999) begin
            InputSwitches = 4'($urandom);
            EnterPswd = ($urandom_range(1) == 1);
            LogOutPulse = ($urandom_range(3) == 0);
            @(negedge Clk);
        end
        EnterPswd = 1'b0;
        LogOutPulse = 1'b0;
        mark("lock_last_cycle", mk(3, 0, 0, 3));
        @(negedge Clk);
        mark("lock_release", mk(0, 0, 0, 0));
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_nm.pop_front();
            n_chk++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s got %h expected %h", nm, g, e);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t e, g; string nm;
        keys(24'h47, 2);
        mark("to_two_digits", mk(0, 0, 2, 0));
        repeat (4999) @(negedge Clk);
        mark("to_before_edge", mk(0, 0, 2, 0));
        @(negedge Clk);
        mark("to_fired", mk(0, 0, 0, 0));
        keys(24'h4700, 4);
        repeat (5000) @(negedge Clk);
        mark("to_in_pswd", mk(0, 0, 0, 0));
        keys(24'h4, 1);
        repeat (4999) @(negedge Clk);
        keys(24'h7, 1);
        mark("to_digit_wins", mk(0, 0, 2, 0));
        keys(24'h00, 2);
        mark("id_4700", mk(1, 0, 0, 0));
        keys(24'hEEE420, 6);
        mark("auth_user2", mk(2, 2, 0, 0));
        logout();
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_nm.pop_front();
            n_chk++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s got %h expected %h", nm, g, e);
            end
        end
    endtask

    task automatic test_logout_simul();
        obs_t e, g; string nm;
        keys(24'h5928, 4);
        keys(24'hF24630, 6);
        mark("auth_user3", mk(2, 3, 0, 0));
        logout();
        mark("logout_user3", mk(0, 0, 0, 0));
        keys(24'h59, 2);
        mark("partial_59", mk(0, 0, 2, 0));
        InputSwitches = 4'h2;
        EnterPswd = 1'b1;
        LogOutPulse = 1'b1;
        @(negedge Clk);
        EnterPswd = 1'b0;
        LogOutPulse = 1'b0;
        mark("simul_discard", mk(0, 0, 0, 0));
        keys(24'h2071, 4);
        logout();
        mark("pswd_abort", mk(0, 0, 0, 0));
        keys(24'h2071, 4);
        keys(24'hAAB431, 6);
        mark("auth_user4", mk(2, 4, 0, 0));
        logout();
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_nm.pop_front();
            n_chk++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s got %h expected %h", nm, g, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t e, g; string nm;
        keys(24'h8522, 4);
        keys(24'hA54, 3);
        #2 Reset = 1'b0;
        #1 mark("rst_mid_pswd", mk(0, 0, 0, 0));
        @(negedge Clk);
        Reset = 1'b1;
        keys(24'h1111, 4);
        keys(24'h1111, 4);
        keys(24'h1111, 4);
        mark("relock", mk(3, 0, 0, 3));
        repeat (10) @(negedge Clk);
        #2 Reset = 1'b0;
        #1 mark("rst_mid_lock", mk(0, 0, 0, 0));
        @(negedge Clk);
        Reset = 1'b1;
        keys(24'h1111, 4);
        mark("fail_after_rst", mk(0, 0, 0, 1));
        keys(24'h8522, 4);
        keys(24'hA54E32, 6);
        mark("auth_after_rst", mk(2, 1, 0, 0));
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_nm.pop_front();
            n_chk++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s got %h expected %h", nm, g, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bad_pswd();
        test_back_to_back_login();
        test_lockout();
        test_timeout();
        test_logout_simul();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
